// File: rtl/subadd_counter_pkg.sv
// Shared definitions for the subadd_counter library: count-direction encodings and default geometry.
// Build option: COUNTER_SAT_EN selects saturating rather than wrap-around counting in subadd_counter.
package subadd_counter_pkg;
  localparam int DEFAULT_W       = 5;
  localparam int DEFAULT_MOD_MAX = 31;

  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DN = 1'b1;
endpackage

// File: rtl/subadd_n.sv
// N-bit add/subtract: b is inverted when sub is high, and sub doubles as the carry-in (two's complement).
module subadd_n #(
  parameter int N = 6
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] b_x;

  assign b_x         = b ^ {N{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_x} + {{N{1'b0}}, sub};
endmodule

// File: rtl/subadd_counter.sv
// Modulo up/down counter with runtime step, registered count, terminal-count pulse and zero flag.
// Define COUNTER_SAT_EN to saturate at 0/MOD_MAX instead of wrapping modulo MOD_MAX+1.
module subadd_counter
  import subadd_counter_pkg::*;
#(
  parameter int W       = DEFAULT_W,
  parameter int MOD_MAX = DEFAULT_MOD_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         mode,
  input  logic [W-1:0] step,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         busy_zero
);
  localparam logic [W:0]   MOD_TOP   = (W+1)'(MOD_MAX);
  localparam logic [W:0]   MOD_SPAN  = (W+1)'(MOD_MAX + 1);
  localparam logic [W-1:0] MOD_MAX_W = W'(MOD_MAX);

  logic [W:0]   step_sum;
  logic         step_cout;
  logic [W:0]   fix_sum;
  logic         fix_cout;
  logic         wrap;
  logic [W-1:0] count_nxt;
  logic         tc_nxt;
  logic         unused_bits;

  // One extra bit of headroom so count+step and count-step never lose information.
  subadd_n #(.N(W+1)) u_step (
    .a    ({1'b0, count}),
    .b    ({1'b0, step}),
    .sub  (mode),
    .sum  (step_sum),
    .cout (step_cout)
  );

  // Modulus correction: pull an overflowed sum back down, or lift a borrowed difference up.
  subadd_n #(.N(W+1)) u_fix (
    .a    (step_sum),
    .b    (MOD_SPAN),
    .sub  (mode == MODE_UP),
    .sum  (fix_sum),
    .cout (fix_cout)
  );

  // Carry-out of the subtract is the inverted borrow.
  assign wrap = (mode == MODE_UP) ? (step_sum > MOD_TOP) : !step_cout;

`ifdef COUNTER_SAT_EN
  assign unused_bits = ^{fix_cout, fix_sum};
`else
  assign unused_bits = ^{fix_cout, fix_sum[W]};
`endif

  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > MOD_MAX_W) ? MOD_MAX_W : load_val;
    end else if (en) begin
      if (wrap) begin
        tc_nxt = 1'b1;
`ifdef COUNTER_SAT_EN
        count_nxt = (mode == MODE_UP) ? MOD_MAX_W : '0;
`else
        count_nxt = fix_sum[W-1:0];
`endif
      end else begin
        count_nxt = step_sum[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      tc        <= 1'b0;
      busy_zero <= 1'b1;
    end else begin
      count     <= count_nxt;
      tc        <= tc_nxt;
      busy_zero <= (count_nxt == '0);
    end
  end
endmodule
